switch_debouncer: RTL and testbench

Input-conditioning stage between the board slide switches and the arithmetic/display path. It synchronizes the raw `sw` bus into the `clock` domain and filters contact bounce. A new switch value is forwarded only after it has held steady for a programmable number of cycles. Its `sw_stable` output drives the A/B operand inputs of the math block and the seven-segment decoder in the top level, so operands never glitch mid-scan.

---
 rtl/switch_debouncer.sv | 73 +++++++
 tb/tb_switch_debouncer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Two/three-flop synchronizer plus hold-time filter for slide switches; an update lands SYNC_STAGES+STABLE_CYCLES+1 edges after a clean step.
// `SWITCH_SYNC3_EN selects a 3-flop synchronizer; there is no backpressure, and the output is purely registered.
module switch_debouncer #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             changed,
  output logic             busy
);

`ifdef SWITCH_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] candidate;
  logic [CW-1:0]    count;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= sw_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Any change on the synchronized bus restarts the hold window, so a bounce
  // back to the current output simply drops the candidate without a pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      candidate <= '0;
      sw_stable <= '0;
      count     <= '0;
      changed   <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (sync != candidate) begin
        candidate <= sync;
        count     <= '0;
      end else if (candidate != sw_stable) begin
        if (count == COUNT_LAST) begin
          sw_stable <= candidate;
          changed   <= 1'b1;
          count     <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        count <= '0;
      end
    end
  end

  assign busy = (candidate != sw_stable);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench: STABLE_CYCLES=4 on the main instance, STABLE_CYCLES=1 on a second.
module tb_switch_debouncer;

`ifdef SWITCH_SYNC3_EN
  localparam int SYNC = 3;
`else
  localparam int SYNC = 2;
`endif
  localparam int LAT  = SYNC + 4 + 1;
  localparam int LAT1 = SYNC + 1 + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw_raw, sw_raw1;
  logic [7:0] sw_stable, sw_stable1;
  logic       changed, changed1, busy, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_debouncer #(.WIDTH(8), .STABLE_CYCLES(4)) dut (
    .clock(clk), .reset(reset), .sw_raw(sw_raw),
    .sw_stable(sw_stable), .changed(changed), .busy(busy)
  );

  switch_debouncer #(.WIDTH(8), .STABLE_CYCLES(1)) dut1 (
    .clock(clk), .reset(reset), .sw_raw(sw_raw1),
    .sw_stable(sw_stable1), .changed(changed1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [7:0] v);
    sw_raw = v;
    repeat (LAT + 3) tick();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    sw_raw = 8'hA5;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (sw_stable !== 8'h00 || changed !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold k=%0d got stable=%h changed=%b busy=%b want 00/0/0",
                 k, sw_stable, changed, busy);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      checks++;
      if (sw_stable !== ((k >= LAT) ? 8'hA5 : 8'h00) || changed !== (k == LAT)) begin
        errors++;
        $display("FAIL reset_release k=%0d got stable=%h changed=%b want %h/%b",
                 k, sw_stable, changed, (k >= LAT) ? 8'hA5 : 8'h00, k == LAT);
      end
    end
  endtask

  task automatic test_step();
    int pulses = 0;
    settle(8'h00);
    sw_raw = 8'h3C;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      if (changed === 1'b1) pulses++;
      checks++;
      if (sw_stable !== ((k >= LAT) ? 8'h3C : 8'h00) ||
          busy !== (k > SYNC && k < LAT)) begin
        errors++;
        $display("FAIL step k=%0d got stable=%h busy=%b want %h/%b",
                 k, sw_stable, busy, (k >= LAT) ? 8'h3C : 8'h00, k > SYNC && k < LAT);
      end
      checks++;
      if (changed !== (k == LAT)) begin
        errors++;
        $display("FAIL step_changed k=%0d got %b want %b", k, changed, k == LAT);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL step_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_bounce_restart();
    int pulses = 0;
    settle(8'h00);
    sw_raw = 8'h3C;
    repeat (3) begin
      tick();
      if (changed === 1'b1) pulses++;
    end
    sw_raw = 8'h00;
    tick();
    if (changed === 1'b1) pulses++;
    sw_raw = 8'h3C;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      if (changed === 1'b1) pulses++;
      checks++;
      if (sw_stable !== ((k >= LAT) ? 8'h3C : 8'h00)) begin
        errors++;
        $display("FAIL bounce_restart k=%0d got stable=%h want %h",
                 k, sw_stable, (k >= LAT) ? 8'h3C : 8'h00);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL bounce_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int busy_seen = 0;
    settle(8'h00);
    sw_raw = 8'h01;
    tick();
    tick();
    sw_raw = 8'h00;
    for (int k = 1; k <= LAT + 4; k++) begin
      tick();
      if (changed === 1'b1) pulses++;
      if (busy === 1'b1) busy_seen++;
      checks++;
      if (sw_stable !== 8'h00) begin
        errors++;
        $display("FAIL glitch_stable k=%0d got %h want 00", k, sw_stable);
      end
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_end got pulses=%0d busy=%b want 0/0", pulses, busy);
    end
    checks++;
    if (busy_seen == 0) begin
      errors++;
      $display("FAIL glitch_busy got busy_seen=0 want >0");
    end
  endtask

  task automatic test_reset_mid_count();
    settle(8'h00);
    sw_raw = 8'hFF;
    repeat (SYNC + 2) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy got %b want 1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (sw_stable !== 8'h00 || busy !== 1'b0 || changed !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear got stable=%h busy=%b changed=%b want 00/0/0",
               sw_stable, busy, changed);
    end
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      checks++;
      if (sw_stable !== ((k >= LAT) ? 8'hFF : 8'h00) || changed !== (k == LAT)) begin
        errors++;
        $display("FAIL midreset_release k=%0d got stable=%h changed=%b want %h/%b",
                 k, sw_stable, changed, (k >= LAT) ? 8'hFF : 8'h00, k == LAT);
      end
    end
  endtask

  task automatic test_min_stable();
    sw_raw1 = 8'h00;
    repeat (LAT1 + 2) tick();
    sw_raw1 = 8'h5A;
    for (int k = 1; k <= LAT1 + 1; k++) begin
      tick();
      checks++;
      if (sw_stable1 !== ((k >= LAT1) ? 8'h5A : 8'h00) || changed1 !== (k == LAT1)) begin
        errors++;
        $display("FAIL min_stable k=%0d got stable=%h changed=%b want %h/%b",
                 k, sw_stable1, changed1, (k >= LAT1) ? 8'h5A : 8'h00, k == LAT1);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    sw_raw  = 8'h00;
    sw_raw1 = 8'h00;
    test_reset();
    test_step();
    test_bounce_restart();
    test_glitch();
    test_reset_mid_count();
    test_min_stable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
